// File: rtl/cpu_pkg.sv
// cpu_pkg: shared hazard-controller FSM states and default memory-stall timeout.
package cpu_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam int MEM_TIMEOUT_DEF = 1024;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping stall/bubble/flush performance counters, built only with HAZARD_PERF_EN.
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        bubble,
  input  logic        flush,
  output logic [31:0] stall_cyc,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      stall_cyc  <= stall_cyc + {31'd0, stall};
      bubble_cnt <= bubble_cnt + {31'd0, bubble};
      flush_cnt  <= flush_cnt + {31'd0, flush};
    end
  end
endmodule
`endif

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/mem-stall/branch-flush hazard control; HAZARD_PERF_EN adds perf counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  idrs1_i,
  input  logic [4:0]  idrs2_i,
  input  logic [4:0]  exRd_i,
  input  logic        exMemRead_i,
  input  logic        branch_taken_i,
  input  logic        mem_stall_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        memStall_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cyc_o,
  output logic [31:0] bubble_cnt_o,
  output logic [31:0] flush_cnt_o
);
  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);
  state_t      state, state_nxt;
  logic        flush_pend, pend_nxt, load_use, flush;
  logic [15:0] wait_cnt, cnt_nxt;
  assign load_use = exMemRead_i && exRd_i != 5'd0 && (exRd_i == idrs1_i || exRd_i == idrs2_i);
  assign flush    = !mem_stall_i && !load_use && (branch_taken_i || flush_pend);
  always_comb begin
    state_nxt     = mem_stall_i ? MEM_WAIT : RUN;
    pend_nxt      = (state == MEM_WAIT && mem_stall_i && branch_taken_i) ? 1'b1 : flush ? 1'b0 : flush_pend;
    cnt_nxt       = !mem_stall_i ? 16'd0 : wait_cnt < TMO ? wait_cnt + 16'd1 : wait_cnt;
    pc_write_o    = !rst_i && !mem_stall_i && !load_use;
    ifid_write_o  = !rst_i && !mem_stall_i && !load_use;
    ifid_flush_o  = rst_i || flush;
    idex_bubble_o = rst_i || (!mem_stall_i && load_use);
    memStall_o    = !rst_i && mem_stall_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= RUN;
      flush_pend      <= 1'b0;
      wait_cnt        <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= pend_nxt;
      wait_cnt   <= cnt_nxt;
      if (cnt_nxt == TMO) stall_timeout_o <= 1'b1;
    end
  end
`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf (
    .clk(clk_i),
    .rst(rst_i),
    .stall(memStall_o),
    .bubble(idex_bubble_o && !rst_i),
    .flush(ifid_flush_o && !rst_i),
    .stall_cyc(stall_cyc_o),
    .bubble_cnt(bubble_cnt_o),
    .flush_cnt(flush_cnt_o)
  );
`else
  assign stall_cyc_o  = '0;
  assign bubble_cnt_o = '0;
  assign flush_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random checks of hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int T = 4;
  logic clk = 1'b0, rst;
  logic [4:0] rs1, rs2, rd;
  logic mr, br, ms;
  logic pc_w, ifid_w, ifid_fl, bub, mstall, tmo;
  logic [31:0] sc, bc, fc;
  int total = 0, bad = 0;
  bit pend, in_wait, tmo_m;
  int run_len;
  int unsigned n_stall, n_bub, n_fl;
  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst), .idrs1_i(rs1), .idrs2_i(rs2), .exRd_i(rd),
    .exMemRead_i(mr), .branch_taken_i(br), .mem_stall_i(ms),
    .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_fl),
    .idex_bubble_o(bub), .memStall_o(mstall), .stall_timeout_o(tmo),
    .stall_cyc_o(sc), .bubble_cnt_o(bc), .flush_cnt_o(fc)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] perf(input int unsigned v);
`ifdef HAZARD_PERF_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction
  task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic m, input logic bch, input logic s);
    bit lu, f;
    logic [4:0] e;
    rst = r; rs1 = a; rs2 = b; rd = d; mr = m; br = bch; ms = s;
    #2;
    lu = m && d != 0 && (d == a || d == b);
    f  = !r && !s && !lu && (bch || pend);
    e  = r ? 5'b00110 : s ? 5'b00001 : lu ? 5'b00010 : {2'b11, f, 2'b00};
    check("ctl{pc,ifw,fl,bub,ms}", {27'd0, pc_w, ifid_w, ifid_fl, bub, mstall}, {27'd0, e});
    @(posedge clk);
    if (r) begin
      pend = 0; in_wait = 0; run_len = 0; tmo_m = 0; n_stall = 0; n_bub = 0; n_fl = 0;
    end else begin
      if (s && in_wait && bch) pend = 1;
      else if (f) pend = 0;
      in_wait = s;
      run_len = s ? (run_len < T ? run_len + 1 : run_len) : 0;
      if (run_len >= T) tmo_m = 1;
      n_stall += s;
      n_bub += (!s && lu);
      n_fl += f;
    end
    #1;
    check("timeout", {31'd0, tmo}, {31'd0, tmo_m});
    check("stall_cyc", sc, perf(n_stall));
    check("bubble_cnt", bc, perf(n_bub));
    check("flush_cnt", fc, perf(n_fl));
    @(negedge clk);
  endtask
  initial begin
    {pend, in_wait, tmo_m} = '0;
    run_len = 0; n_stall = 0; n_bub = 0; n_fl = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 3, 3, 3, 1, 0, 0);
    // load-use on rs2, then the exRd=0 variant
    step(0, 1, 5, 5, 1, 0, 0);
    step(0, 1, 2, 7, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    // three stall cycles with a branch in the second one
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // load-use together with a taken branch
    step(0, 9, 2, 9, 1, 1, 0);
    step(0, 9, 2, 4, 1, 1, 0);
    // timeout: sticky after the 4th stall edge
    repeat (4) step(0, 0, 0, 0, 0, 0, 1);
    check("tmo_after4", {31'd0, tmo}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("tmo_sticky", {31'd0, tmo}, 32'd1);
    // reset mid-stall with a pending flush
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    check("tmo_cleared", {31'd0, tmo}, 32'd0);
    check("sc_after_rst", sc, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // perf counter scenario: 2 stalls, 1 bubble, 1 flush
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 6, 1, 6, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("perf_stall", sc, perf(2));
    check("perf_bubble", bc, perf(1));
    check("perf_flush", fc, perf(1));
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 3, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 45);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 1024, consecutive MEM_WAIT cycles before timeout flag; legal range 1..65535.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port idrs1_i  input  5  rs1 of instruction in ID.
REQ-005 SHALL have port idrs2_i  input  5  rs2 of instruction in ID.
REQ-006 SHALL have port exRd_i  input  5  Rd held in ID/EX register.
REQ-007 SHALL have port exMemRead_i  input  1  ID/EX instruction is a load.
REQ-008 SHALL have port branch_taken_i  input  1  branch resolved taken in ID this cycle.
REQ-009 SHALL have port mem_stall_i  input  1  data cache busy; pipeline must freeze.
REQ-010 SHALL have port pc_write_o  output  1  PC update enable.
REQ-011 SHALL have port ifid_write_o  output  1  IF/ID register load enable.
REQ-012 SHALL have port ifid_flush_o  output  1  clear IF/ID to NOP.
REQ-013 SHALL have port idex_bubble_o  output  1  zero control fields loaded into ID/EX.
REQ-014 SHALL have port memStall_o  output  1  freeze to ID/EX, EX/MEM, MEM/WB registers.
REQ-015 SHALL have port stall_timeout_o  output  1  sticky mem-stall timeout flag.
REQ-016 SHALL have ports stall_cyc_o, bubble_cnt_o, flush_cnt_o  output  32 each  performance counters.

Function
REQ-017 SHALL implement FSM with states RUN and MEM_WAIT; RUN->MEM_WAIT when mem_stall_i=1; MEM_WAIT->RUN on first cycle mem_stall_i=0.
REQ-018 SHALL drive memStall_o = mem_stall_i combinationally (zero latency) in both states.
REQ-019 SHALL, while mem_stall_i=1, drive pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, ifid_flush_o=0 (freeze, no bubble).
REQ-020 SHALL detect load-use when exMemRead_i=1, exRd_i!=0, and exRd_i equals idrs1_i or idrs2_i.
REQ-021 SHALL, on load-use with mem_stall_i=0, drive pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0 for that cycle.
REQ-022 SHALL ignore branch_taken_i during a load-use cycle; ID re-evaluates the branch next cycle.
REQ-023 SHALL, in MEM_WAIT, set register flush_pend when branch_taken_i=1; flush_pend holds until consumed.
REQ-024 SHALL assert ifid_flush_o=1 on a non-stall, non-load-use cycle when branch_taken_i=1 or flush_pend=1; flush_pend clears that cycle.
REQ-025 SHALL, with no stall, no load-use, no flush, drive pc_write_o=1, ifid_write_o=1, others 0.
REQ-026 SHALL give priority mem_stall > load-use > flush; flush_pend survives a load-use cycle.
REQ-027 SHALL count consecutive MEM_WAIT cycles in a 16-bit counter, cleared on RUN, saturating at MEM_TIMEOUT.
REQ-028 SHALL set stall_timeout_o when that counter reaches MEM_TIMEOUT; cleared only by rst_i.

Reset
REQ-029 SHALL, on rising edge with rst_i=1, set state=RUN, flush_pend=0, timeout counter=0, stall_timeout_o=0, all perf counters=0.
REQ-030 SHALL, while rst_i=1, drive pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, memStall_o=0, regardless of other inputs.
REQ-031 SHALL discard a pending flush and in-progress stall on reset mid-operation.

Configuration
REQ-032 SHALL, with HAZARD_PERF_EN defined, increment stall_cyc_o per memStall_o cycle, bubble_cnt_o per idex_bubble_o cycle (not during reset), flush_cnt_o per ifid_flush_o cycle (not during reset); all wrap at 2^32.
REQ-033 SHALL, without HAZARD_PERF_EN, keep the three counter ports present and tied to 0 with no counter flops.

Structure
REQ-034 SHALL place the FSM state enum (RUN, MEM_WAIT) and default MEM_TIMEOUT constant in shared package cpu_pkg.
REQ-035 SHALL use one sub-module, hazard_perf_cnt, holding the three perf counters, instantiated only under HAZARD_PERF_EN.

Verification
REQ-036 SHALL cover load-use: exMemRead_i=1, exRd_i=5, idrs2_i=5 -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for exactly that cycle; exRd_i=0 variant -> no stall.
REQ-037 SHALL cover stall with branch: mem_stall_i=1 for 3 cycles, branch_taken_i=1 on cycle 2 -> outputs frozen 3 cycles, ifid_flush_o=1 on cycle 4 only.
REQ-038 SHALL cover simultaneous load-use and branch_taken_i=1 -> idex_bubble_o=1, ifid_flush_o=0; next cycle hazard gone, branch_taken_i=1 -> ifid_flush_o=1.
REQ-039 SHALL cover timeout with MEM_TIMEOUT=4: mem_stall_i=1 for 4 cycles -> stall_timeout_o=1 after 4th edge, stays 1 after stall drops until rst_i.
REQ-040 SHALL cover reset mid-stall: flush_pend set in MEM_WAIT, rst_i pulsed 1 cycle -> state RUN, no ifid_flush_o after reset release, counters 0.
REQ-041 SHALL cover counters with HAZARD_PERF_EN: 2 stall cycles, 1 bubble, 1 flush -> stall_cyc_o=2, bubble_cnt_o=1, flush_cnt_o=1; without macro all read 0.
